placer_stream_sequencer: RTL and testbench

//  Synthesizable loader/unloader for the systolic placer. Streams a packetised bitstream from a

---
 rtl/placer_stream_sequencer.sv | 165 ++++++++++++++++
 tb/tb_placer_stream_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/placer_stream_sequencer.sv
// Streams packetised bitstream words from a synchronous ROM into the systolic placer,
// fires the run trigger, then captures the unload stream while complete is high.
module placer_stream_sequencer #(
   parameter int BUS_WIDTH   = 32,
   parameter int HEADER_LEN  = 1,
   parameter int PACKET_LEN  = 16,
   parameter int NUM_PACKETS = 10,
   parameter int PACKET_GAP  = 20,
   parameter int START_DELAY = 10,
   parameter int NUM_RUNS    = 1,
   parameter int TIMEOUT     = 0,
   parameter int ADDR_W      = $clog2(HEADER_LEN + PACKET_LEN * NUM_PACKETS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [BUS_WIDTH-1:0] mem_rdata,
   output logic                 load_enable,
   output logic [BUS_WIDTH-1:0] load_data,
   input  logic                 complete,
   input  logic [BUS_WIDTH-1:0] unload_data,
   output logic                 cap_valid,
   output logic [BUS_WIDTH-1:0] cap_data,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output logic [15:0]          run_count
);
   localparam int MAX_A   = (PACKET_GAP > PACKET_LEN) ? PACKET_GAP : PACKET_LEN;
   localparam int MAX_B   = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PKT_W   = $clog2(NUM_PACKETS + 1);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(HEADER_LEN);

   typedef enum logic [3:0] {
      S_IDLE, S_GAP, S_STROBE, S_BODY, S_SDELAY, S_TRIGGER, S_WAIT, S_UNLOAD, S_DONE
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [PKT_W-1:0]   pkt_reg;
   logic [16:0]        run_total;

   assign run_total = {1'b0, run_count} + 17'd1;

   // Each state produces the outputs of the following cycle; mem_addr runs one word ahead of
   // the consuming state so the ROM latency plus the output register give a 2-cycle path.
   always_ff @(posedge clk) begin
      if (reset || abort) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         pkt_reg     <= '0;
         mem_addr    <= BASE_ADDR;
         load_enable <= 1'b0;
         load_data   <= '0;
         cap_valid   <= 1'b0;
         cap_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         run_count   <= '0;
      end else begin
         load_enable <= 1'b0;
         load_data   <= '0;
         cap_valid   <= 1'b0;
         cap_data    <= '0;
         done        <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  run_count   <= '0;
                  timeout_err <= 1'b0;
                  mem_addr    <= BASE_ADDR;
                  cnt_reg     <= '0;
                  pkt_reg     <= '0;
                  busy        <= 1'b1;
                  state_reg   <= S_GAP;
               end
            end
            S_GAP: begin
               if (cnt_reg == CNT_W'(PACKET_GAP - 1)) begin
                  cnt_reg   <= '0;
                  mem_addr  <= mem_addr + 1'b1;
                  state_reg <= S_STROBE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_STROBE: begin
               load_enable <= 1'b1;
               load_data   <= mem_rdata;
               mem_addr    <= mem_addr + 1'b1;
               cnt_reg     <= '0;
               state_reg   <= S_BODY;
            end
            S_BODY: begin
               load_data <= mem_rdata;
               if (cnt_reg == CNT_W'(PACKET_LEN - 2)) begin
                  cnt_reg <= '0;
                  if (pkt_reg == PKT_W'(NUM_PACKETS - 1)) begin
                     pkt_reg   <= '0;
                     state_reg <= (START_DELAY == 0) ? S_TRIGGER : S_SDELAY;
                  end else begin
                     pkt_reg   <= pkt_reg + 1'b1;
                     state_reg <= S_GAP;
                  end
               end else begin
                  cnt_reg  <= cnt_reg + 1'b1;
                  mem_addr <= mem_addr + 1'b1;
               end
            end
            S_SDELAY: begin
               if (cnt_reg == CNT_W'(START_DELAY - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= S_TRIGGER;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_TRIGGER: begin
               load_enable <= 1'b1;
               cnt_reg     <= '0;
               state_reg   <= S_WAIT;
            end
            S_WAIT: begin
               if (complete) begin
                  cap_valid <= 1'b1;
                  cap_data  <= unload_data;
                  state_reg <= S_UNLOAD;
               end else if (TIMEOUT != 0 && cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state_reg   <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_UNLOAD: begin
               if (complete) begin
                  cap_valid <= 1'b1;
                  cap_data  <= unload_data;
               end else begin
                  if (run_count != 16'hFFFF) run_count <= run_count + 1'b1;
                  if (NUM_RUNS != 0 && run_total == 17'(NUM_RUNS)) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= S_DONE;
                  end else begin
                     mem_addr  <= BASE_ADDR;
                     cnt_reg   <= '0;
                     pkt_reg   <= '0;
                     state_reg <= S_GAP;
                  end
               end
            end
            S_DONE:  state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_placer_stream_sequencer.sv
// Randomised scoreboard bench: expected output events are queued as stimulus is issued and
// a negedge monitor pops and compares every cycle in which the sequencer presents something.
module tb_placer_stream_sequencer;
   localparam int BW = 8, H = 1, L = 3, N = 2, G = 2, SD = 1, NR = 3, TO = 50;
   localparam int AW = $clog2(H + L * N + 1);

   logic clk, reset, start, abort, complete;
   logic [AW-1:0] mem_addr;
   logic [BW-1:0] mem_rdata, load_data, unload_data, cap_data;
   logic load_enable, cap_valid, busy, done, timeout_err;
   logic [15:0] run_count;
   logic [BW-1:0] rom [0:(1<<AW)-1];

   typedef struct {
      int kind;                // 0 strobe, 1 body, 2 trigger, 3 cap, 4 done
      logic le; logic [BW-1:0] ld; logic cv; logic [BW-1:0] cd;
      logic dn; logic bsy; logic [15:0] rc; logic te;
      int delta;               // cycles since previous event, -1 = unconstrained
   } ev_t;

   ev_t exp_q[$];
   int n_tests = 0, n_fail = 0;
   bit mon_en = 0;
   int mon_cyc = 0, mon_last = 0;

   placer_stream_sequencer #(
      .BUS_WIDTH(BW), .HEADER_LEN(H), .PACKET_LEN(L), .NUM_PACKETS(N), .PACKET_GAP(G),
      .START_DELAY(SD), .NUM_RUNS(NR), .TIMEOUT(TO), .ADDR_W(AW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .load_enable(load_enable), .load_data(load_data),
      .complete(complete), .unload_data(unload_data), .cap_valid(cap_valid),
      .cap_data(cap_data), .busy(busy), .done(done), .timeout_err(timeout_err),
      .run_count(run_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) mem_rdata <= rom[mem_addr];

   function automatic string kname(int k);
      case (k)
         0: return "strobe";
         1: return "body";
         2: return "trigger";
         3: return "cap";
         default: return "done";
      endcase
   endfunction

   function automatic ev_t mk(int kind, logic le, logic [BW-1:0] ld, logic cv, logic [BW-1:0] cd,
                              logic dn, logic bsy, logic [15:0] rc, logic te, int delta);
      ev_t e;
      e.kind = kind; e.le = le; e.ld = ld; e.cv = cv; e.cd = cd;
      e.dn = dn; e.bsy = bsy; e.rc = rc; e.te = te; e.delta = delta;
      return e;
   endfunction

   function automatic logic [36:0] outs();
      return {load_enable, load_data, cap_valid, cap_data, done, busy, run_count, timeout_err};
   endfunction

   // Monitor: any cycle with a strobe/trigger, load word, capture or done is an event.
   initial begin
      ev_t e;
      logic [36:0] exp_v;
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (mon_en && (load_enable || load_data != '0 || cap_valid || done)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event cyc=%0d actual le=%0b ld=%0h cv=%0b cd=%0h done=%0b required none",
                        mon_cyc, load_enable, load_data, cap_valid, cap_data, done);
            end else begin
               e = exp_q.pop_front();
               exp_v = {e.le, e.ld, e.cv, e.cd, e.dn, e.bsy, e.rc, e.te};
               if (outs() !== exp_v || (e.delta >= 0 && (mon_cyc - mon_last) != e.delta)) begin
                  n_fail++;
                  $display("FAIL ev_%s actual le=%0b ld=%0h cv=%0b cd=%0h done=%0b busy=%0b rc=%0d te=%0b dt=%0d required le=%0b ld=%0h cv=%0b cd=%0h done=%0b busy=%0b rc=%0d te=%0b dt=%0d",
                           kname(e.kind), load_enable, load_data, cap_valid, cap_data, done, busy,
                           run_count, timeout_err, mon_cyc - mon_last, e.le, e.ld, e.cv, e.cd,
                           e.dn, e.bsy, e.rc, e.te, e.delta);
               end else begin
                  $display("[TB] ev %s ok ld=%0h cd=%0h rc=%0d", kname(e.kind), load_data, cap_data, run_count);
               end
            end
            mon_last = mon_cyc;
         end
      end
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end else begin
         $display("[TB] %s ok = %0h", name, act);
      end
   endtask

   task automatic fill_rom();
      for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom_range(1, 255));
   endtask

   // One run's load stream: G idle cycles before each strobe, SD idle cycles before trigger.
   task automatic push_load_run(int rc, logic te);
      for (int p = 0; p < N; p++)
         for (int w = 0; w < L; w++) begin
            int a = H + p * L + w;
            if (w == 0)
               exp_q.push_back(mk(0, 1'b1, rom[a], 1'b0, '0, 1'b0, 1'b1, 16'(rc), te, (p == 0) ? -1 : G + 1));
            else
               exp_q.push_back(mk(1, 1'b0, rom[a], 1'b0, '0, 1'b0, 1'b1, 16'(rc), te, 1));
         end
      exp_q.push_back(mk(2, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 16'(rc), te, SD + 1));
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for the trigger (load_enable with zero data); pulses start once while busy.
   task automatic wait_trigger(int poke);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         start = (i == poke);
         @(negedge clk);
         if (load_enable && load_data == '0) found = 1;
      end
      start = 1'b0;
      if (!found) begin
         n_tests++; n_fail++;
         $display("FAIL trigger_wait actual=absent required=trigger within 200 cycles");
      end
   endtask

   task automatic drive_caps(int d, int k, bit fixed, int rc);
      repeat (d) @(negedge clk);
      for (int i = 0; i < k; i++) begin
         complete = 1'b1;
         unload_data = fixed ? 8'(5 + i) : 8'($urandom_range(0, 255));
         exp_q.push_back(mk(3, 1'b0, '0, 1'b1, unload_data, 1'b0, 1'b1, 16'(rc), 1'b0, (i == 0) ? -1 : 1));
         @(negedge clk);
      end
      complete = 1'b0;
      unload_data = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic seq_normal(bit fixed);
      fill_rom();
      mon_en = 1;
      push_load_run(0, 1'b0);
      do_start();
      for (int r = 0; r < NR; r++) begin
         bit f = fixed && (r == 0);
         wait_trigger($urandom_range(1, 10));
         drive_caps(f ? 0 : $urandom_range(0, 8), f ? 4 : $urandom_range(1, 5), f, r);
         if (r < NR - 1) push_load_run(r + 1, 1'b0);
         else exp_q.push_back(mk(4, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 16'(NR), 1'b0, -1));
      end
      wait_drain();
      repeat (3) @(negedge clk);
      check("idle_after_done", {63'd0, busy}, 64'd0);
      mon_en = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; complete = 1'b0; unload_data = '0;
      fill_rom();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", {27'd0, outs()}, 64'd0);
      check("reset_addr", {{(64-AW){1'b0}}, mem_addr}, 64'(H));

      seq_normal(1'b1);

      // Timeout: complete never rises, done + timeout_err exactly TO cycles after trigger.
      fill_rom();
      mon_en = 1;
      push_load_run(0, 1'b0);
      do_start();
      wait_trigger(5);
      exp_q.push_back(mk(4, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 16'd0, 1'b1, TO));
      wait_drain();
      repeat (5) @(negedge clk);
      check("timeout_sticky", {63'd0, timeout_err}, 64'd1);
      check("timeout_idle", {63'd0, busy}, 64'd0);
      mon_en = 0;

      seq_normal(1'b0);   // events expect te=0, so the new start must clear timeout_err

      // Abort mid-BODY together with a start pulse.
      fill_rom();
      do_start();
      begin
         bit seen = 0;
         for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (load_enable && load_data != '0) seen = 1;
         end
         check("abort_strobe_seen", {63'd0, seen}, 64'd1);
      end
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      check("abort_outputs", {27'd0, outs()}, 64'd0);
      check("abort_addr", {{(64-AW){1'b0}}, mem_addr}, 64'(H));
      repeat (5) @(negedge clk);
      check("abort_stays_idle", {63'd0, busy}, 64'd0);

      // Reset in the middle of an unload.
      fill_rom();
      do_start();
      wait_trigger(500);
      complete = 1'b1;
      unload_data = 8'hA5;
      repeat (3) @(negedge clk);
      check("unload_active", {63'd0, cap_valid}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_unload_outputs", {27'd0, outs()}, 64'd0);
      check("reset_unload_addr", {{(64-AW){1'b0}}, mem_addr}, 64'(H));
      reset = 1'b0; complete = 1'b0;
      @(negedge clk);

      seq_normal(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
